// File: rtl/write_buffer_pkg.sv
// Shared definitions for the posted-write buffer: bus widths agreed with the
// processor and memory_controller, and the memory-side FSM encoding.
package write_buffer_pkg;

    localparam int WB_ADDR_WIDTH = 32;
    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_DEPTH      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } wb_state_t;

endpackage

// File: rtl/wb_store.sv
// Circular store queue for the write buffer, with a parallel lookup that
// returns the youngest queued entry whose address matches.
module wb_store
    import write_buffer_pkg::*;
#(
    parameter int DEPTH      = WB_DEPTH,
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH = WB_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    push,
    input  logic [ADDR_WIDTH-1:0]   push_addr,
    input  logic [DATA_WIDTH-1:0]   push_data,
    input  logic                    pop,
    input  logic [ADDR_WIDTH-1:0]   lookup_addr,
    output logic                    hit,
    output logic [DATA_WIDTH-1:0]   hit_data,
    output logic [ADDR_WIDTH-1:0]   head_addr,
    output logic [DATA_WIDTH-1:0]   head_data,
    output logic [ADDR_WIDTH-1:0]   next_addr,
    output logic [DATA_WIDTH-1:0]   next_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [PTR_W-1:0]      head_next;

    assign head_next = head + PTR_W'(1);
    assign full      = (count == CNT_W'(DEPTH));
    assign head_addr = addr_mem[head];
    assign head_data = data_mem[head];
    assign next_addr = addr_mem[head_next];
    assign next_data = data_mem[head_next];

    // Entry contents need no reset; validity comes only from head and count.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail] <= push_addr;
            data_mem[tail] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head_next;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        logic [PTR_W-1:0] idx;
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + i[PTR_W-1:0];
            if ((CNT_W'(i) < count) && (addr_mem[idx] == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = data_mem[idx];
            end
        end
    end

endmodule

// File: rtl/write_buffer.sv
// Posted-write buffer: queues processor stores, drains them to memory in the
// background, forwards loads from queued stores and serialises load misses.
module write_buffer
    import write_buffer_pkg::*;
#(
    parameter int DEPTH      = WB_DEPTH,
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH = WB_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  write,
    input  logic                  trans,
    output logic                  stall,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_write,
    output logic                  mem_trans,
    input  logic                  mem_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    wb_state_t             state;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  is_store;
    logic                  is_load;
    logic                  push;
    logic                  pop;
    logic                  miss;
    logic                  hit;
    logic                  full;
    logic [CNT_W-1:0]      count;
    logic [DATA_WIDTH-1:0] hit_data;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [DATA_WIDTH-1:0] next_data;

    assign is_store = trans && write;
    assign is_load  = trans && !write;
    assign push     = is_store && !full;
    assign pop      = (state == WRITE) && mem_ready;
    assign miss     = is_load && !hit;

    // A full queue stalls even when a pop lands on the same edge.
    assign stall = (is_store && full) || (miss && (state != RESP));

    always_comb begin
        rdata = '0;
        if (is_load && hit) begin
            rdata = hit_data;
        end else if (state == RESP) begin
            rdata = rdata_q;
        end
    end

    wb_store #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_store (
        .clk         (clk),
        .n_reset     (n_reset),
        .push        (push),
        .push_addr   (addr),
        .push_data   (wdata),
        .pop         (pop),
        .lookup_addr (addr),
        .hit         (hit),
        .hit_data    (hit_data),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .next_addr   (next_addr),
        .next_data   (next_data),
        .count       (count),
        .full        (full)
    );

    // A store arriving into an empty queue is launched on its own enqueue
    // edge, so the memory write starts the very next cycle.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state     <= IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_write <= 1'b0;
            mem_trans <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state     <= WRITE;
                        mem_addr  <= head_addr;
                        mem_wdata <= head_data;
                        mem_write <= 1'b1;
                        mem_trans <= 1'b1;
                    end else if (push) begin
                        state     <= WRITE;
                        mem_addr  <= addr;
                        mem_wdata <= wdata;
                        mem_write <= 1'b1;
                        mem_trans <= 1'b1;
                    end else if (miss) begin
                        state     <= READ;
                        mem_addr  <= addr;
                        mem_write <= 1'b0;
                        mem_trans <= 1'b1;
                    end else begin
                        mem_trans <= 1'b0;
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        if (count > CNT_W'(1)) begin
                            mem_addr  <= next_addr;
                            mem_wdata <= next_data;
                        end else if (push) begin
                            mem_addr  <= addr;
                            mem_wdata <= wdata;
                        end else begin
                            state     <= IDLE;
                            mem_write <= 1'b0;
                            mem_trans <= 1'b0;
                        end
                    end
                end
                READ: begin
                    if (mem_ready) begin
                        rdata_q   <= mem_rdata;
                        state     <= RESP;
                        mem_trans <= 1'b0;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    mem_trans <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_write_buffer.sv
// Scenario bench for write_buffer: each task drives one scenario and checks
// stall/rdata inline, while a scoreboard checks every accepted memory transfer.
module tb_write_buffer;

    logic        clk;
    logic        n_reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        write;
    logic        trans;
    logic        stall;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_write;
    logic        mem_trans;
    logic        mem_ready;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t exp_q[$];
    int   tests_run;
    int   tests_failed;

    write_buffer #(
        .DEPTH      (4),
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .write     (write),
        .trans     (trans),
        .stall     (stall),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_write (mem_write),
        .mem_trans (mem_trans),
        .mem_ready (mem_ready)
    );

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h80) return 32'h77;
        return a ^ 32'hC0DE0000;
    endfunction

    assign mem_rdata = mem_fn(mem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every accepted memory transfer must match the oldest expected one.
    always @(negedge clk) begin : monitor
        txn_t e;
        if (n_reset && mem_trans && mem_ready) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL unexpected_txn: got write=%0b addr=%h, expected no transfer",
                         mem_write, mem_addr);
            end else begin
                e = exp_q.pop_front();
                if (mem_write !== e.wr || mem_addr !== e.addr || (e.wr && mem_wdata !== e.data)) begin
                    tests_failed++;
                    $display("[TB] FAIL mem_txn: got write=%0b addr=%h data=%h, expected write=%0b addr=%h data=%h",
                             mem_write, mem_addr, mem_wdata, e.wr, e.addr, e.data);
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input bit expect_txn);
        trans = 1'b1;
        write = 1'b1;
        addr  = a;
        wdata = d;
        if (expect_txn) exp_q.push_back('{wr: 1'b1, addr: a, data: d});
    endtask

    task automatic idle_bus();
        trans = 1'b0;
        write = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int i;
        i = 0;
        while (i < 40 && (exp_q.size() != 0 || mem_trans)) begin
            cycle();
            i++;
        end
        tests_run++;
        if (exp_q.size() != 0 || mem_trans !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d pending transfers, expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run += 6;
        if (mem_trans !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mem_trans: got %b, expected 0", mem_trans); end
        if (mem_write !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mem_write: got %b, expected 0", mem_write); end
        if (mem_addr !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_mem_addr: got %h, expected 0", mem_addr); end
        if (mem_wdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_mem_wdata: got %h, expected 0", mem_wdata); end
        if (stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_stall: got %b, expected 0", stall); end
        if (rdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_rdata: got %h, expected 0", rdata); end
        cycle();
        n_reset = 1'b1;
        cycle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [3];
        logic [31:0] d [3];
        a = '{32'h10, 32'h14, 32'h18};
        d = '{32'hA, 32'hB, 32'hC};
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_store(a[i], d[i], 1'b1);
            @(negedge clk);
            tests_run++;
            if (stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_stall: got %b, expected 0", stall); end
            if (i > 0) begin
                tests_run++;
                if (mem_trans !== 1'b1 || mem_addr !== a[i-1]) begin
                    tests_failed++;
                    $display("[TB] FAIL b2b_order: got trans=%b addr=%h, expected trans=1 addr=%h", mem_trans, mem_addr, a[i-1]);
                end
            end
            cycle();
        end
        idle_bus();
        @(negedge clk);
        tests_run++;
        if (mem_trans !== 1'b1 || mem_addr !== a[2]) begin
            tests_failed++;
            $display("[TB] FAIL b2b_last: got trans=%b addr=%h, expected trans=1 addr=%h", mem_trans, mem_addr, a[2]);
        end
        cycle();
        @(negedge clk);
        tests_run++;
        if (mem_trans !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_idle: got %b, expected 0", mem_trans); end
        cycle();
    endtask

    task automatic test_full_stall();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_store(32'h100 + 32'(4 * i), 32'h30 + 32'(i), 1'b1);
            @(negedge clk);
            tests_run++;
            if (stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL fill_stall: got %b, expected 0", stall); end
            cycle();
        end
        drive_store(32'h200, 32'h99, 1'b1);
        @(negedge clk);
        tests_run++;
        if (stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_stall: got %b, expected 1", stall); end
        cycle();
        mem_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_pop_bubble: got %b, expected 1", stall); end
        cycle();
        @(negedge clk);
        tests_run++;
        if (stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_accept: got %b, expected 0", stall); end
        cycle();
        idle_bus();
        wait_drain("full_drain");
    endtask

    task automatic test_forward();
        mem_ready = 1'b0;
        drive_store(32'h20, 32'h1, 1'b1);
        cycle();
        drive_store(32'h20, 32'h2, 1'b1);
        cycle();
        trans = 1'b1;
        write = 1'b0;
        addr  = 32'h20;
        @(negedge clk);
        tests_run += 2;
        if (stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL fwd_stall: got %b, expected 0", stall); end
        if (rdata !== 32'h2) begin tests_failed++; $display("[TB] FAIL fwd_rdata: got %h, expected 2", rdata); end
        cycle();
        addr = 32'h24;
        @(negedge clk);
        tests_run += 2;
        if (stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL fwd_miss_stall: got %b, expected 1", stall); end
        if (rdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL fwd_miss_rdata: got %h, expected 0", rdata); end
        cycle();
        idle_bus();
        mem_ready = 1'b1;
        wait_drain("fwd_drain");
    endtask

    task automatic load_until_done(input logic [31:0] a, input int wait_lo, input int wait_hi,
                                   input string name, output int stalls);
        bit done;
        stalls = 0;
        done   = 1'b0;
        trans  = 1'b1;
        write  = 1'b0;
        addr   = a;
        exp_q.push_back('{wr: 1'b0, addr: a, data: 32'h0});
        for (int j = 0; j < 16 && !done; j++) begin
            mem_ready = !(j >= wait_lo && j <= wait_hi);
            @(negedge clk);
            if (j >= wait_lo && j <= wait_hi) begin
                tests_run++;
                if (mem_trans !== 1'b1 || mem_addr !== a || mem_write !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL %s_hold: got trans=%b addr=%h, expected trans=1 addr=%h", name, mem_trans, mem_addr, a);
                end
            end
            if (stall) begin
                stalls++;
                cycle();
            end else begin
                done = 1'b1;
            end
        end
        tests_run += 2;
        if (!done) begin tests_failed++; $display("[TB] FAIL %s_timeout: got stall=1, expected completion", name); end
        if (rdata !== mem_fn(a)) begin tests_failed++; $display("[TB] FAIL %s_rdata: got %h, expected %h", name, rdata, mem_fn(a)); end
        cycle();
        idle_bus();
        mem_ready = 1'b1;
    endtask

    task automatic test_miss_after_drain();
        int stalls;
        mem_ready = 1'b1;
        drive_store(32'h40, 32'h5, 1'b1);
        cycle();
        load_until_done(32'h80, 99, 99, "miss_drain", stalls);
        tests_run++;
        if (stalls != 3) begin tests_failed++; $display("[TB] FAIL miss_drain_stalls: got %0d, expected 3", stalls); end
        wait_drain("miss_drain_empty");
    endtask

    task automatic test_read_wait();
        int stalls;
        load_until_done(32'h300, 1, 2, "read_wait", stalls);
        tests_run++;
        if (stalls != 4) begin tests_failed++; $display("[TB] FAIL read_wait_stalls: got %0d, expected 4", stalls); end
        wait_drain("read_wait_empty");
    endtask

    task automatic test_reset_mid_drain();
        int stalls;
        int seen;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_store(32'h500 + 32'(4 * i), 32'h60 + 32'(i), 1'b0);
            cycle();
        end
        idle_bus();
        @(negedge clk);
        tests_run++;
        if (mem_trans !== 1'b1 || mem_write !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL rst_pre_write: got trans=%b write=%b, expected 1/1", mem_trans, mem_write);
        end
        #1;
        n_reset = 1'b0;
        #1;
        tests_run += 2;
        if (mem_trans !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_async_trans: got %b, expected 0", mem_trans); end
        if (mem_addr !== 32'h0) begin tests_failed++; $display("[TB] FAIL rst_async_addr: got %h, expected 0", mem_addr); end
        cycle();
        mem_ready = 1'b1;
        n_reset   = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_trans) seen++;
            cycle();
        end
        tests_run++;
        if (seen != 0) begin tests_failed++; $display("[TB] FAIL rst_no_writes: got %0d transfer cycles, expected 0", seen); end
        load_until_done(32'h500, 99, 99, "rst_queue_empty", stalls);
        tests_run++;
        if (stalls != 2) begin tests_failed++; $display("[TB] FAIL rst_queue_empty_stalls: got %0d, expected 2", stalls); end
        wait_drain("rst_final");
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        n_reset      = 1'b0;
        trans        = 1'b0;
        write        = 1'b0;
        addr         = '0;
        wdata        = '0;
        mem_ready    = 1'b1;
        test_reset();
        test_back_to_back();
        test_full_stall();
        test_forward();
        test_miss_after_drain();
        test_read_wait();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
